synth_voice: RTL

Single monophonic synthesiser voice feeding the I2S transmitter's 16-bit `signal` input. It contains:
- a phase-accumulator oscillator with selectable waveform,
- a linear attack/release envelope gated by note_on/note_off pulses,
- an internal sample-rate tick derived from clk48m.
The output is one signed 16-bit sample per tick, held stable between ticks so the downstream latch always sees a settled value.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/synth_env.sv | 72 +++++++
 rtl/synth_voice.sv | 105 ++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice: envelope states, waveform codes and widths.
package synth_pkg;

    localparam int ENV_W    = 12;
    localparam int ENV_MAX  = 4095;
    localparam int PHASE_W  = 24;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SILENCE  = 2'd3
    } wave_t;

endpackage

// File: rtl/synth_env.sv
// Linear attack/release envelope: state machine plus 12-bit level register.
// Note events act on any clock edge; level only moves on sample ticks.
module synth_env
    import synth_pkg::*;
#(
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8
) (
    input  logic             clk48m,
    input  logic             rst,
    input  logic             tick,
    input  logic             note_on,
    input  logic             note_off,
    output logic [ENV_W-1:0] level,
    output logic             active
);

    env_state_t       state;
    env_state_t       state_nxt;
    logic [ENV_W-1:0] level_nxt;
    logic [ENV_W:0]   up_sum;

    // Event transitions override the tick-driven ones; the level update uses the pre-edge state.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        up_sum    = {1'b0, level} + (ENV_W+1)'(ATTACK_STEP);

        if (tick) begin
            case (state)
                ENV_IDLE: level_nxt = '0;
                ENV_ATTACK: begin
                    if (up_sum >= (ENV_W+1)'(ENV_MAX)) begin
                        level_nxt = ENV_W'(ENV_MAX);
                        state_nxt = ENV_SUSTAIN;
                    end else begin
                        level_nxt = up_sum[ENV_W-1:0];
                    end
                end
                ENV_SUSTAIN: level_nxt = ENV_W'(ENV_MAX);
                ENV_RELEASE: begin
                    if (level <= ENV_W'(RELEASE_STEP)) begin
                        level_nxt = '0;
                        state_nxt = ENV_IDLE;
                    end else begin
                        level_nxt = level - ENV_W'(RELEASE_STEP);
                    end
                end
                default: level_nxt = '0;
            endcase
        end

        if (note_on && (state == ENV_IDLE || state == ENV_RELEASE)) begin
            state_nxt = ENV_ATTACK;
        end else if (note_off && (state == ENV_ATTACK || state == ENV_SUSTAIN)) begin
            state_nxt = ENV_RELEASE;
        end
    end

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            state  <= ENV_IDLE;
            level  <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            active <= (state_nxt != ENV_IDLE);
        end
    end

endmodule

// File: rtl/synth_voice.sv
// Monophonic voice: tick divider, phase oscillator, envelope and output scaling.
// Define SYNTH_TRIANGLE_EN to enable the triangle waveform on wave_sel=2.
module synth_voice
    import synth_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1024,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8
) (
    input  logic                clk48m,
    input  logic                rst,
    input  logic                note_on,
    input  logic                note_off,
    input  logic [PHASE_W-1:0]  phase_inc,
    input  logic [1:0]          wave_sel,
    output logic [SAMPLE_W-1:0] signal,
    output logic                sample_valid,
    output logic                active
);

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PROD_W = SAMPLE_W + ENV_W;

    logic [CNT_W-1:0]           tick_cnt;
    logic                       tick;
    logic                       tick_d;
    logic [PHASE_W-1:0]         phase;
    logic [ENV_W-1:0]           level;
    logic [SAMPLE_W-1:0]        p;
    logic signed [SAMPLE_W-1:0] wave;
    logic signed [PROD_W-1:0]   product;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // A note starting from silence restarts the waveform; a retrigger from release does not.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (note_on && !active) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase + phase_inc;
        end
    end

    synth_env #(
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) u_env (
        .clk48m  (clk48m),
        .rst     (rst),
        .tick    (tick),
        .note_on (note_on),
        .note_off(note_off),
        .level   (level),
        .active  (active)
    );

    assign p = phase[PHASE_W-1 -: SAMPLE_W];

`ifdef SYNTH_TRIANGLE_EN
    logic [SAMPLE_W-1:0] tri_fold;
    assign tri_fold = p[SAMPLE_W-1] ? ~p : p;
`endif

    always_comb begin
        wave = '0;
        case (wave_t'(wave_sel))
            WAVE_SAW:      wave = $signed(p ^ 16'h8000);
            WAVE_SQUARE:   wave = phase[PHASE_W-1] ? 16'sh8000 : 16'sh7FFF;
`ifdef SYNTH_TRIANGLE_EN
            WAVE_TRIANGLE: wave = $signed({tri_fold[SAMPLE_W-2:0], 1'b0} ^ 16'h8000);
`endif
            default:       wave = '0;
        endcase
    end

    // Full-scale products fit in 28 signed bits, so the top product bit is never needed.
    assign product = wave * $signed({1'b0, level});

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            tick_d       <= 1'b0;
            sample_valid <= 1'b0;
            signal       <= '0;
        end else begin
            tick_d       <= tick;
            sample_valid <= tick_d;
            if (tick_d) begin
                signal <= product[ENV_W +: SAMPLE_W];
            end
        end
    end

endmodule
